button_event_decoder: RTL

BUTTON_EVENT_DECODER -- requirements
Module: button_event_decoder

---
 rtl/button_event_decoder_if.sv | 21 ++
 rtl/button_event_decoder.sv | 124 ++++++++++++
 2 files changed

// File: rtl/button_event_decoder_if.sv
// rtl/button_event_decoder_if.sv - button level/abort inputs and decoded button event outputs
interface button_event_decoder_if;
    logic       btn_level;
    logic       clear;
    logic       press;
    logic       release_pulse;
    logic       long_press;
    logic       repeat_pulse;
    logic       held;
    logic [7:0] rep_count;

    modport master (
        output btn_level, clear,
        input  press, release_pulse, long_press, repeat_pulse, held, rep_count
    );

    modport slave (
        input  btn_level, clear,
        output press, release_pulse, long_press, repeat_pulse, held, rep_count
    );
endinterface

// File: rtl/button_event_decoder.sv
// rtl/button_event_decoder.sv - press/release/long-press/auto-repeat decoder for a debounced button
// Auto-repeat in the LONG state is built only when BUTTON_EVENT_REPEAT_EN is defined.
module button_event_decoder #(
    parameter int LONG_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000,
    parameter int CNT_W         = 26
) (
    input  logic                        clk,
    input  logic                        rst,
    button_event_decoder_if.slave       bus
);

    typedef enum logic [1:0] {
        WAIT_LOW = 2'd0,
        IDLE     = 2'd1,
        PRESSED  = 2'd2,
        LONG     = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             press_q;
    logic             release_q;
    logic             long_q;
    logic             held_q;

`ifdef BUTTON_EVENT_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
    logic       repeat_q;
    logic [7:0] rep_q;
`else
    localparam int unused_repeat_cycles = REPEAT_CYCLES;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= WAIT_LOW;
            cnt       <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            held_q    <= 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
            repeat_q  <= 1'b0;
            rep_q     <= 8'd0;
`endif
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
            repeat_q  <= 1'b0;
`endif
            // An abort re-arms the low-level requirement so a stuck button cannot re-press.
            if (bus.clear) begin
                state  <= WAIT_LOW;
                held_q <= 1'b0;
                cnt    <= '0;
            end else begin
                case (state)
                    WAIT_LOW: begin
                        if (!bus.btn_level) state <= IDLE;
                    end
                    IDLE: begin
                        if (bus.btn_level) begin
                            state   <= PRESSED;
                            press_q <= 1'b1;
                            held_q  <= 1'b1;
                            cnt     <= '0;
`ifdef BUTTON_EVENT_REPEAT_EN
                            rep_q   <= 8'd0;
`endif
                        end
                    end
                    PRESSED: begin
                        if (!bus.btn_level) begin
                            state     <= IDLE;
                            release_q <= 1'b1;
                            held_q    <= 1'b0;
                        end else if (cnt == LONG_LAST) begin
                            state  <= LONG;
                            long_q <= 1'b1;
                            cnt    <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    LONG: begin
                        if (!bus.btn_level) begin
                            state     <= IDLE;
                            release_q <= 1'b1;
                            held_q    <= 1'b0;
                        end
`ifdef BUTTON_EVENT_REPEAT_EN
                        else if (cnt == REP_LAST) begin
                            repeat_q <= 1'b1;
                            cnt      <= '0;
                            if (rep_q != 8'hFF) rep_q <= rep_q + 8'd1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
`endif
                    end
                    default: state <= WAIT_LOW;
                endcase
            end
        end
    end

    assign bus.press         = press_q;
    assign bus.release_pulse = release_q;
    assign bus.long_press    = long_q;
    assign bus.held          = held_q;
`ifdef BUTTON_EVENT_REPEAT_EN
    assign bus.repeat_pulse  = repeat_q;
    assign bus.rep_count     = rep_q;
`else
    assign bus.repeat_pulse  = 1'b0;
    assign bus.rep_count     = 8'd0;
`endif

endmodule
